// File: rtl/min4_u8_if.sv
// -----------------------------------------------------------------------------
// min4_u8_if
//
// Bundles the operand/sample inputs and every result output of min4_u8 so the
// block can be connected with a single port. The clock and reset are not part
// of the bundle and stay plain ports on the block.
//
// Signals:
//   a, b, c, d  [7:0]  unsigned operands
//   in_valid           current a..d is a sample to capture on the next edge
//   run_clr            synchronous clear of the running minimum
//   min        [7:0]   combinational minimum of a..d
//   min_idx    [1:0]   combinational winner index (0=a, 1=b, 2=c, 3=d)
//   min_q      [7:0]   registered min
//   min_idx_q  [1:0]   registered min_idx
//   out_valid          min_q/min_idx_q hold the sample captured on the last edge
//   run_min    [7:0]   smallest min over accepted samples since reset/clear
//   run_valid          at least one sample accepted since reset/clear
//
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the min4_u8 block itself
// -----------------------------------------------------------------------------
interface min4_u8_if;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic       in_valid;
    logic       run_clr;
    logic [7:0] min;
    logic [1:0] min_idx;
    logic [7:0] min_q;
    logic [1:0] min_idx_q;
    logic       out_valid;
    logic [7:0] run_min;
    logic       run_valid;

    modport master (
        output a, b, c, d, in_valid, run_clr,
        input  min, min_idx, min_q, min_idx_q, out_valid, run_min, run_valid
    );

    modport slave (
        input  a, b, c, d, in_valid, run_clr,
        output min, min_idx, min_q, min_idx_q, out_valid, run_min, run_valid
    );
endinterface

// File: rtl/min4_u8.sv
// -----------------------------------------------------------------------------
// min4_u8
//
// Unsigned 8-bit minimum-of-four selector. The primary result (min, min_idx)
// is purely combinational and independent of clock, reset and in_valid. A
// registered copy with a valid flag and a running minimum across accepted
// samples are provided for pipelined consumers.
//
// Ports:
//   clk     rising-edge clock for all registers
//   areset  asynchronous, active-high reset of all registers
//   bus     min4_u8_if.slave: operands a..d, in_valid, run_clr in;
//           min, min_idx, min_q, min_idx_q, out_valid, run_min, run_valid out
//
// Flow control: there is no backpressure. in_valid qualifies a..d at the
// rising edge where it is high, and that sample is always accepted. out_valid
// is high for exactly the cycle after each accepted sample; min_q/min_idx_q
// hold their last captured value while out_valid is low.
// -----------------------------------------------------------------------------
module min4_u8 (
    input  logic       clk,
    input  logic       areset,
    min4_u8_if.slave   bus
);

    // -------------------------------------------------------------------------
    // Combinational ordered scan. Strict less-than means a later operand only
    // displaces the current winner when it is smaller, so ties resolve to the
    // lowest index.
    // -------------------------------------------------------------------------
    logic [7:0] min_c;
    logic [1:0] idx_c;

    always_comb begin
        min_c = bus.a;
        idx_c = 2'd0;
        if (bus.b < min_c) begin
            min_c = bus.b;
            idx_c = 2'd1;
        end
        if (bus.c < min_c) begin
            min_c = bus.c;
            idx_c = 2'd2;
        end
        if (bus.d < min_c) begin
            min_c = bus.d;
            idx_c = 2'd3;
        end
    end

    assign bus.min     = min_c;
    assign bus.min_idx = idx_c;

    // -------------------------------------------------------------------------
    // Registered copy of the combinational result.
    // -------------------------------------------------------------------------
    logic [7:0] min_q_r;
    logic [1:0] min_idx_q_r;
    logic       out_valid_r;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            min_q_r     <= 8'h00;
            min_idx_q_r <= 2'd0;
            out_valid_r <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                min_q_r     <= min_c;
                min_idx_q_r <= idx_c;
            end
            out_valid_r <= bus.in_valid;
        end
    end

    // -------------------------------------------------------------------------
    // Running minimum. run_clr has priority and discards any sample offered in
    // the same cycle (that sample still lands in min_q above). The clear value
    // 8'hFF is the identity for min, so the first accepted sample always ends
    // up in run_min, including a sample whose minimum is itself 8'hFF.
    // -------------------------------------------------------------------------
    logic [7:0] run_min_r;
    logic       run_valid_r;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            run_min_r   <= 8'hFF;
            run_valid_r <= 1'b0;
        end else if (bus.run_clr) begin
            run_min_r   <= 8'hFF;
            run_valid_r <= 1'b0;
        end else if (bus.in_valid) begin
            if (min_c < run_min_r) begin
                run_min_r <= min_c;
            end
            run_valid_r <= 1'b1;
        end
    end

    assign bus.min_q     = min_q_r;
    assign bus.min_idx_q = min_idx_q_r;
    assign bus.out_valid = out_valid_r;
    assign bus.run_min   = run_min_r;
    assign bus.run_valid = run_valid_r;

endmodule

// File: tb/tb_min4_u8.sv
// -----------------------------------------------------------------------------
// tb_min4_u8
//
// Self-checking bench for min4_u8: a table of fixed combinational vectors,
// hand-written sequences for the registered path, running minimum, clear and
// asynchronous reset, and a randomized phase compared against a behavioural
// reference model.
// -----------------------------------------------------------------------------
module tb_min4_u8;

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic areset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    min4_u8_if bus ();

    min4_u8 dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus.slave)
    );

    // ---------------------------------------------------------------- bookkeeping
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Minimum value is the smallest of the four; the index is the first
    // position holding that value.
    function automatic logic [9:0] ref_min(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
        logic [7:0] v [4];
        logic [7:0] m;
        logic [1:0] idx;
        v   = '{a, b, c, d};
        m   = 8'hFF;
        idx = 2'd0;
        foreach (v[i]) if (v[i] < m) m = v[i];
        for (int i = 3; i >= 0; i--) if (v[i] == m) idx = 2'(i);
        return {idx, m};
    endfunction

    logic [9:0] exp_q [$];
    logic [7:0] m_q;
    logic [1:0] m_idx_q;
    logic       m_ov;
    logic [7:0] m_run;
    logic       m_rv;

    task automatic model_reset();
        m_q     = 8'h00;
        m_idx_q = 2'd0;
        m_ov    = 1'b0;
        m_run   = 8'hFF;
        m_rv    = 1'b0;
        exp_q.delete();
    endtask

    // Apply one rising edge to the model using the inputs that were stable
    // across that edge.
    task automatic model_edge();
        logic [9:0] r;
        r = ref_min(bus.a, bus.b, bus.c, bus.d);
        m_ov = bus.in_valid;
        if (bus.in_valid) begin
            exp_q.push_back(r);
            {m_idx_q, m_q} = r;
        end
        if (bus.run_clr) begin
            m_run = 8'hFF;
            m_rv  = 1'b0;
        end else if (bus.in_valid) begin
            if (r[7:0] < m_run) m_run = r[7:0];
            m_rv = 1'b1;
        end
    endtask

    task automatic check_comb(input string tag);
        logic [9:0] r;
        r = ref_min(bus.a, bus.b, bus.c, bus.d);
        check({tag, "_min"},     32'(bus.min),     32'(r[7:0]));
        check({tag, "_min_idx"}, 32'(bus.min_idx), 32'(r[9:8]));
    endtask

    task automatic check_regs(input string tag);
        logic [9:0] e;
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(m_ov));
        if (m_ov) begin
            if (exp_q.size() == 0) begin
                check({tag, "_scoreboard_empty"}, 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check({tag, "_sb_q"}, 32'({bus.min_idx_q, bus.min_q}), 32'(e));
            end
        end
        check({tag, "_min_q"},     32'(bus.min_q),     32'(m_q));
        check({tag, "_min_idx_q"}, 32'(bus.min_idx_q), 32'(m_idx_q));
        check({tag, "_run_min"},   32'(bus.run_min),   32'(m_run));
        check({tag, "_run_valid"}, 32'(bus.run_valid), 32'(m_rv));
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic v, input logic clr);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.d        = d;
        bus.in_valid = v;
        bus.run_clr  = clr;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check_regs(tag);
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        logic [7:0] e_min;
        logic [1:0] e_idx;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 2'd0};
        vecs[1] = '{8'h11, 8'h02, 8'h03, 8'h04, 8'h02, 2'd1};
        vecs[2] = '{8'h11, 8'h12, 8'h03, 8'h04, 8'h03, 2'd2};
        vecs[3] = '{8'h11, 8'h12, 8'h13, 8'h04, 8'h04, 2'd3};
        vecs[4] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h11, 2'd0};
        vecs[5] = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 2'd0};
        vecs[6] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 2'd1};
        vecs[7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0};

        bus.a = 8'h00; bus.b = 8'h00; bus.c = 8'h00; bus.d = 8'h00;
        bus.in_valid = 1'b0;
        bus.run_clr  = 1'b0;
        areset = 1'b1;
        model_reset();

        // Reset state, with a sample offered during reset that must be ignored.
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_min_q",     32'(bus.min_q),     32'h00);
        check("rst_min_idx_q", 32'(bus.min_idx_q), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_run_min",   32'(bus.run_min),   32'hFF);
        check("rst_run_valid", 32'(bus.run_valid), 32'h0);
        check_comb("rst_comb");
        bus.in_valid = 1'b0;
        @(negedge clk);
        areset = 1'b0;

        // Fixed combinational vectors.
        foreach (vecs[i]) begin
            bus.a = vecs[i].a; bus.b = vecs[i].b; bus.c = vecs[i].c; bus.d = vecs[i].d;
            #1;
            check($sformatf("vec%0d_min", i),     32'(bus.min),     32'(vecs[i].e_min));
            check($sformatf("vec%0d_min_idx", i), 32'(bus.min_idx), 32'(vecs[i].e_idx));
        end

        // Registered path: capture, then hold with out_valid low.
        drive(8'h20, 8'h10, 8'h30, 8'h40, 1'b1, 1'b0);
        tick("reg_cap");
        check("reg_cap_min_q_const",  32'(bus.min_q),     32'h10);
        check("reg_cap_idx_q_const",  32'(bus.min_idx_q), 32'h1);
        check("reg_cap_valid_const",  32'(bus.out_valid), 32'h1);
        drive(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0);
        tick("reg_hold");
        check("reg_hold_valid_const", 32'(bus.out_valid), 32'h0);
        check("reg_hold_min_q_const", 32'(bus.min_q),     32'h10);

        // Running minimum over mins 30, 10, 50, starting from a clear.
        drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        tick("run_clr0");
        drive(8'h30, 8'h40, 8'h50, 8'h60, 1'b1, 1'b0);
        tick("run_s30");
        check("run_s30_const", 32'(bus.run_min), 32'h30);
        drive(8'h70, 8'h10, 8'h80, 8'h90, 1'b1, 1'b0);
        tick("run_s10");
        check("run_s10_const", 32'(bus.run_min), 32'h10);
        drive(8'h50, 8'h60, 8'h70, 8'h80, 1'b1, 1'b0);
        tick("run_s50");
        check("run_s50_const",    32'(bus.run_min),   32'h10);
        check("run_s50_rv_const", 32'(bus.run_valid), 32'h1);
        // Clear together with a sample: running path clears, min_q still captures.
        drive(8'h33, 8'h22, 8'h11, 8'h44, 1'b1, 1'b1);
        tick("run_clrv");
        check("run_clrv_run_const", 32'(bus.run_min),   32'hFF);
        check("run_clrv_rv_const",  32'(bus.run_valid), 32'h0);
        check("run_clrv_q_const",   32'(bus.min_q),     32'h11);
        // A lone 8'hFF sample after a clear still sets run_valid.
        drive(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
        tick("run_ff");
        check("run_ff_rv_const", 32'(bus.run_valid), 32'h1);

        // Asynchronous reset between edges with a pending sample.
        drive(8'h05, 8'h06, 8'h07, 8'h08, 1'b1, 1'b0);
        tick("ar_pre");
        drive(8'h09, 8'h03, 8'h07, 8'h08, 1'b1, 1'b0);
        #2;
        areset = 1'b1;
        #1;
        check("ar_min_q",     32'(bus.min_q),     32'h00);
        check("ar_min_idx_q", 32'(bus.min_idx_q), 32'h0);
        check("ar_out_valid", 32'(bus.out_valid), 32'h0);
        check("ar_run_min",   32'(bus.run_min),   32'hFF);
        check("ar_run_valid", 32'(bus.run_valid), 32'h0);
        check_comb("ar_comb");
        bus.d = 8'h01;
        #1;
        check("ar_track_min",     32'(bus.min),     32'h01);
        check("ar_track_min_idx", 32'(bus.min_idx), 32'h3);
        @(posedge clk);
        #1;
        check("ar_hold_out_valid", 32'(bus.out_valid), 32'h0);
        check("ar_hold_run_valid", 32'(bus.run_valid), 32'h0);
        @(negedge clk);
        areset = 1'b0;
        model_reset();
        // First capture happens on the first edge after deassertion.
        tick("ar_first");
        check("ar_first_q_const", 32'(bus.min_q), 32'h01);

        // Randomized phase: inputs change on both clock edges.
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #2;
            {bus.a, bus.b, bus.c, bus.d} = $urandom();
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.run_clr  = ($urandom_range(0, 9) == 0);
            #1;
            check_comb("rnd_neg");
            @(posedge clk);
            #1;
            model_edge();
            check_regs("rnd_edge");
            #1;
            {bus.a, bus.b, bus.c, bus.d} = $urandom();
            #1;
            check_comb("rnd_pos");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/min4_u8.md
# min4_u8

Unsigned 8-bit minimum-of-four selector for datapath compare stages. Its primary result, `min`, is a purely combinational minimum of four operands. It also provides a registered copy of the result with a valid flag, and a running minimum across accepted samples, for downstream pipelined consumers. It has one clock domain and an asynchronous reset.

## Interface
- No parameters; all operand widths are fixed at 8 bits.
- `clk` input, 1 bit: sole clock; all registers update on its rising edge.
- `areset` input, 1 bit: asynchronous, active-high reset.
- `a`, `b`, `c`, `d` input, 8 bits each: unsigned operands.
- `in_valid` input, 1 bit: marks the current `a`..`d` as a sample to capture.
- `run_clr` input, 1 bit: synchronous clear of the running minimum.
- `min` output, 8 bits: combinational minimum of `a`, `b`, `c`, `d`.
- `min_idx` output, 2 bits: combinational index of the winner (0=a, 1=b, 2=c, 3=d).
- `min_q` output, 8 bits: registered `min`.
- `min_idx_q` output, 2 bits: registered `min_idx`.
- `out_valid` output, 1 bit: `min_q`/`min_idx_q` hold a captured sample.
- `run_min` output, 8 bits: smallest `min` over all accepted samples since the last reset or clear.
- `run_valid` output, 1 bit: at least one sample has been accepted since the last reset or clear.

## Operation
- Comparison is unsigned magnitude.
- `min` is computed as an ordered scan: start with `a`; replace it with `b` if `b` < current; then `c` if `c` < current; then `d` if `d` < current.
- Tie-break: strict less-than comparisons, so the lowest index wins. `min_idx` reports that index.
- `min` and `min_idx` depend only on `a`..`d`. They have no dependence on `clk`, `areset` or `in_valid`.
- `min` and `min_idx` must never be X or Z when the inputs are known values.
- On each rising edge with `in_valid`=1:
  - `min_q` <= `min`, `min_idx_q` <= `min_idx`, `out_valid` <= 1.
- On each rising edge with `in_valid`=0:
  - `out_valid` <= 0; `min_q` and `min_idx_q` hold their values.
- Running minimum update at each rising edge, in priority order:
  - `run_clr`=1: `run_min` <= 8'hFF, `run_valid` <= 0. Any `in_valid` in that same cycle is ignored for the running path, but is still captured into `min_q`.
  - `in_valid`=1 and `min` < `run_min`: `run_min` <= `min`.
  - `in_valid`=1: `run_valid` <= 1.
- Reset values:
  - `min_q` = 8'h00, `min_idx_q` = 0, `out_valid` = 0.
  - `run_min` = 8'hFF, `run_valid` = 0.

## Timing
- `min` and `min_idx` have zero latency and settle within the same timestep as an input change. Inputs may change on either clock edge, and the outputs must follow.
- Registered outputs have 1-cycle latency: a sample presented with `in_valid` before edge N appears on `min_q` after edge N.
- `run_min` reflects a sample 1 cycle after it is accepted.
- `areset` asserts immediately, with no clock required, and forces all register reset values. Asynchronous assertion mid-stream discards any pending sample.
- Deassertion of `areset` is synchronised by the surrounding system. The first capture occurs on the first rising edge after deassertion.
- Combinational outputs are unaffected by `areset`.

## Test plan
- Ordered sweep of `{a,b,c,d}`, checking `min`/`min_idx` combinationally:
  - `{01,02,03,04}` -> `min`=01, `min_idx`=0.
  - `{11,02,03,04}` -> `min`=02, `min_idx`=1.
  - `{11,12,03,04}` -> `min`=03, `min_idx`=2.
  - `{11,12,13,04}` -> `min`=04, `min_idx`=3.
  - `{11,12,13,14}` -> `min`=11, `min_idx`=0.
- Ties and extremes:
  - `{05,05,05,05}` -> `min`=05, `min_idx`=0.
  - `{FF,00,00,FF}` -> `min`=00, `min_idx`=1.
  - `{FF,FF,FF,FF}` -> `min`=FF.
- Random sweep: 200 random 32-bit `{a,b,c,d}` vectors, changed on both clock edges. `min` must equal the unsigned minimum at every edge, with no X.
- Registered path: `in_valid`=1 with `{20,10,30,40}` -> next cycle `min_q`=10, `min_idx_q`=1, `out_valid`=1. Then `in_valid`=0 -> `out_valid`=0 with `min_q` held at 10.
- Running minimum: accept samples with mins 30, 10, 50 -> `run_min` reads 30, then 10, then 10, with `run_valid`=1. Assert `run_clr` together with `in_valid` -> `run_min`=FF, `run_valid`=0, while `min_q` still captures that sample.
- Async reset: assert `areset` between clock edges -> all registered outputs take their reset values immediately, while `min` keeps tracking the inputs.
